pow_res_fifo: RTL



---
 rtl/pow_res_fifo_if.sv | 22 ++
 rtl/pow_res_fifo.sv | 59 +++++
 2 files changed

// File: rtl/pow_res_fifo_if.sv
// Handshake bundle between the power pipeline, the result FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the pipeline/consumer side.
interface pow_res_fifo_if #(
  parameter int w = 8
);
  logic         in_vld;
  logic [w-1:0] in_data;
  logic         clk_en;
  logic         out_vld;
  logic         out_rdy;
  logic [w-1:0] out_data;

  modport slave (
    input  in_vld, in_data, out_rdy,
    output clk_en, out_vld, out_data
  );

  modport master (
    output in_vld, in_data, out_rdy,
    input  clk_en, out_vld, out_data
  );
endinterface

// File: rtl/pow_res_fifo.sv
// Circular result FIFO behind the power pipeline; back-pressure is turned into a
// combinational clk_en stall so no final-stage result is ever dropped.
module pow_res_fifo #(
  parameter int w     = 8,
  parameter int depth = 4,
  parameter int cnt_w = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pow_res_fifo_if.slave              bus,
  output logic [$clog2(depth):0]     level,
  output logic [cnt_w-1:0]           out_cnt
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_lvl = (aw+1)'(depth);

  logic [w-1:0]  mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          push;
  logic          pop;

  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
    return (&v) ? v : v + cnt_w'(1);
  endfunction

  // A full FIFO may still accept a word in the same cycle the consumer drains one.
  assign bus.clk_en   = (level != full_lvl) | bus.out_rdy;
  assign bus.out_vld  = (level != '0);
  assign bus.out_data = mem[rd_ptr];

  assign push = bus.clk_en & bus.in_vld;
  assign pop  = bus.out_vld & bus.out_rdy;

  // Storage is data only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      out_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + aw'(1);
        out_cnt <= sat_inc(out_cnt);
      end
      case ({push, pop})
        2'b10:   level <= level + (aw+1)'(1);
        2'b01:   level <= level - (aw+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule
